// File: rtl/cpu_datapath_pkg.sv
// Shared definitions for the bus-based CPU datapath: opcodes, IR field
// positions and the bus-source priority order.
package cpu_datapath_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;

    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;
    localparam int C2_HI = 20;
    localparam int C2_LO = 19;
    localparam int IMM_HI = 18;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [3:0] {
        SRC_NONE, SRC_REG, SRC_HI, SRC_LO, SRC_ZHI,
        SRC_ZLO, SRC_PC, SRC_MDR, SRC_INPORT, SRC_C
    } bus_src_e;

    // Earlier checks win when several sources drive the bus at once.
    function automatic bus_src_e bus_src_sel(input logic reg_any, input logic hi,
                                             input logic lo, input logic zhi,
                                             input logic zlo, input logic pc,
                                             input logic mdr, input logic inport,
                                             input logic c);
        if (reg_any) return SRC_REG;
        if (hi)      return SRC_HI;
        if (lo)      return SRC_LO;
        if (zhi)     return SRC_ZHI;
        if (zlo)     return SRC_ZLO;
        if (pc)      return SRC_PC;
        if (mdr)     return SRC_MDR;
        if (inport)  return SRC_INPORT;
        if (c)       return SRC_C;
        return SRC_NONE;
    endfunction

endpackage

// File: rtl/cpu_datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus, 64-bit result feeds Z.
module cpu_alu
    import cpu_datapath_pkg::*;
(
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [4:0]          op,
    input  logic                inc_pc,
    output logic [2*DATA_W-1:0] result
);

    logic [DATA_W-1:0]   lo;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rem;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] rot_r;
    logic [2*DATA_W-1:0] rot_l;
    logic [4:0]          sh;

    assign sh    = b[4:0];
    assign prod  = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    assign rot_r = {a, a} >> sh;
    assign rot_l = {a, a} << sh;

    always_comb begin
        quo = '0;
        rem = '0;
        if (b != '0) begin
            quo = $signed(a) / $signed(b);
            rem = $signed(a) % $signed(b);
        end
    end

    always_comb begin
        lo = a + b;
        case (op)
            OP_ADD, OP_ADDI, OP_LD, OP_LDI, OP_ST: lo = a + b;
            OP_SUB:          lo = a - b;
            OP_SHR:          lo = a >> sh;
            OP_SHRA:         lo = $signed(a) >>> sh;
            OP_SHL:          lo = a << sh;
            OP_ROR:          lo = rot_r[DATA_W-1:0];
            OP_ROL:          lo = rot_l[2*DATA_W-1:DATA_W];
            OP_AND, OP_ANDI: lo = a & b;
            OP_OR, OP_ORI:   lo = a | b;
            OP_NEG:          lo = '0 - b;
            OP_NOT:          lo = ~b;
            default:         lo = a + b;
        endcase

        if (inc_pc)
            result = {{DATA_W{1'b0}}, b + DATA_W'(1)};
        else if (op == OP_MUL)
            result = prod;
        else if (op == OP_DIV)
            result = {rem, quo};
        else
            result = {{DATA_W{lo[DATA_W-1]}}, lo};
    end

endmodule

// File: rtl/cpu_datapath.sv
// Single-bus CPU datapath: register file, special registers and ALU, all
// moving data over one shared bus under external strobe control.
module cpu_datapath
    import cpu_datapath_pkg::*;
(
    input  logic                Clock,
    input  logic                Clear,
    input  logic                PCout, ZHighout, ZLowout, MDRout, HIout,
    input  logic                LOout, Cout, InPortOut, BAout, Rout,
    input  logic                PCin, IRin, MARin, MDRin, Yin, ZHighIn, ZLowIn,
    input  logic                HIin, LOin, CONin, InPortIn, OutPortIn, Rin,
    input  logic                IncPC,
    input  logic                Read,
    input  logic                RAMin,
    input  logic                GRA, GRB, GRC,
    input  logic [NUM_REGS-1:0] REGin,
    input  logic [NUM_REGS-1:0] REGout,
    input  logic [DATA_W-1:0]   Mdatain,
    input  logic [DATA_W-1:0]   InPort_data,
    output logic [4:0]          opcode,
    output logic [DATA_W-1:0]   OutPort_data,
    output logic [DATA_W-1:0]   bus
);

    logic [DATA_W-1:0]   r_q [NUM_REGS];
    logic [DATA_W-1:0]   r_d [NUM_REGS];
    logic [DATA_W-1:0]   pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
    logic [DATA_W-1:0]   y_q, y_d, hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0]   inport_q, inport_d, outport_q, outport_d;
    logic [2*DATA_W-1:0] z_q, z_d, alu_result;
    logic                con_q, con_d;
    logic [NUM_REGS-1:0] sel, load_vec, drive_vec;
    logic [DATA_W-1:0]   reg_bus, c_sext;
    logic                unused_ok;

    always_comb begin
        sel = '0;
        if (GRA) sel[ir_q[RA_HI:RA_LO]] = 1'b1;
        if (GRB) sel[ir_q[RB_HI:RB_LO]] = 1'b1;
        if (GRC) sel[ir_q[RC_HI:RC_LO]] = 1'b1;
    end

    assign load_vec  = REGin  | (sel & {NUM_REGS{Rin}});
    assign drive_vec = REGout | (sel & {NUM_REGS{Rout | BAout}});
    assign c_sext    = {{(DATA_W-IMM_HI-1){ir_q[IMM_HI]}}, ir_q[IMM_HI:0]};

    // Highest-numbered driven register wins; BAout makes R0 read as zero.
    always_comb begin
        reg_bus = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (drive_vec[i])
                reg_bus = (i == 0 && BAout) ? '0 : r_q[i];
        end
    end

    always_comb begin
        case (bus_src_sel(|drive_vec, HIout, LOout, ZHighout, ZLowout,
                          PCout, MDRout, InPortOut, Cout))
            SRC_REG:    bus = reg_bus;
            SRC_HI:     bus = hi_q;
            SRC_LO:     bus = lo_q;
            SRC_ZHI:    bus = z_q[2*DATA_W-1:DATA_W];
            SRC_ZLO:    bus = z_q[DATA_W-1:0];
            SRC_PC:     bus = pc_q;
            SRC_MDR:    bus = mdr_q;
            SRC_INPORT: bus = inport_q;
            SRC_C:      bus = c_sext;
            default:    bus = '0;
        endcase
    end

    cpu_alu u_alu (
        .a      (y_q),
        .b      (bus),
        .op     (ir_q[OP_HI:OP_LO]),
        .inc_pc (IncPC),
        .result (alu_result)
    );

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++)
            r_d[i] = load_vec[i] ? bus : r_q[i];
        pc_d      = PCin      ? bus : pc_q;
        ir_d      = IRin      ? bus : ir_q;
        mar_d     = MARin     ? bus : mar_q;
        y_d       = Yin       ? bus : y_q;
        hi_d      = HIin      ? bus : hi_q;
        lo_d      = LOin      ? bus : lo_q;
        outport_d = OutPortIn ? bus : outport_q;
        inport_d  = InPortIn  ? InPort_data : inport_q;
        mdr_d     = mdr_q;
        if (MDRin)
            mdr_d = Read ? Mdatain : bus;
        z_d = z_q;
        if (ZLowIn)
            z_d[DATA_W-1:0] = alu_result[DATA_W-1:0];
        if (ZHighIn)
            z_d[2*DATA_W-1:DATA_W] = alu_result[2*DATA_W-1:DATA_W];
        con_d = con_q;
        if (CONin) begin
            case (ir_q[C2_HI:C2_LO])
                2'b00:   con_d = (bus == '0);
                2'b01:   con_d = (bus != '0);
                2'b10:   con_d = ~bus[DATA_W-1];
                default: con_d = bus[DATA_W-1];
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_q[i] <= '0;
            pc_q      <= '0;
            ir_q      <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            y_q       <= '0;
            z_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            con_q     <= 1'b0;
            inport_q  <= '0;
            outport_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                r_q[i] <= r_d[i];
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            y_q       <= y_d;
            z_q       <= z_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            con_q     <= con_d;
            inport_q  <= inport_d;
            outport_q <= outport_d;
        end
    end

    assign opcode       = ir_q[OP_HI:OP_LO];
    assign OutPort_data = outport_q;

    // MAR and CON feed the external memory/branch logic outside this block.
    assign unused_ok = ^{RAMin, mar_q, con_q};

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed fetch/execute sequences plus
// randomized strobes compared every cycle against a behavioural model.
module tb_cpu_datapath;

    logic        Clock, Clear;
    logic        PCout, ZHighout, ZLowout, MDRout, HIout, LOout, Cout, InPortOut, BAout, Rout;
    logic        PCin, IRin, MARin, MDRin, Yin, ZHighIn, ZLowIn, HIin, LOin, CONin, InPortIn, OutPortIn, Rin;
    logic        IncPC, Read, RAMin, GRA, GRB, GRC;
    logic [15:0] REGin, REGout;
    logic [31:0] Mdatain, InPort_data;
    logic [4:0]  opcode;
    logic [31:0] OutPort_data, bus;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_ir, m_mdr, m_y, m_hi, m_lo, m_in, m_out;
    logic [63:0] m_z;
    logic        m_con;

    cpu_datapath dut (
        .Clock(Clock), .Clear(Clear),
        .PCout(PCout), .ZHighout(ZHighout), .ZLowout(ZLowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortOut(InPortOut),
        .BAout(BAout), .Rout(Rout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
        .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .HIin(HIin), .LOin(LOin), .CONin(CONin),
        .InPortIn(InPortIn), .OutPortIn(OutPortIn), .Rin(Rin),
        .IncPC(IncPC), .Read(Read), .RAMin(RAMin), .GRA(GRA), .GRB(GRB), .GRC(GRC),
        .REGin(REGin), .REGout(REGout), .Mdatain(Mdatain), .InPort_data(InPort_data),
        .opcode(opcode), .OutPort_data(OutPort_data), .bus(bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_pc = '0; m_ir = '0; m_mdr = '0; m_y = '0; m_hi = '0; m_lo = '0;
        m_in = '0; m_out = '0; m_z = '0; m_con = 1'b0;
    endfunction

    function automatic logic [15:0] field_sel();
        logic [15:0] s;
        s = '0;
        if (GRA) s[m_ir[26:23]] = 1'b1;
        if (GRB) s[m_ir[22:19]] = 1'b1;
        if (GRC) s[m_ir[18:15]] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_bus();
        logic [15:0] drv;
        logic [31:0] imm;
        drv = REGout | (field_sel() & {16{Rout | BAout}});
        for (int i = 15; i >= 0; i--)
            if (drv[i]) return (i == 0 && BAout) ? 32'd0 : m_r[i];
        if (HIout)     return m_hi;
        if (LOout)     return m_lo;
        if (ZHighout)  return m_z[63:32];
        if (ZLowout)   return m_z[31:0];
        if (PCout)     return m_pc;
        if (MDRout)    return m_mdr;
        if (InPortOut) return m_in;
        if (Cout) begin
            imm = m_ir;
            return {{13{imm[18]}}, imm[18:0]};
        end
        return 32'd0;
    endfunction

    function automatic logic [63:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [4:0] op, input logic inc);
        int sa, sb, s;
        longint p;
        logic [31:0] r;
        sa = a;
        sb = b;
        s = int'(b[4:0]);
        if (inc) return {32'd0, b + 32'd1};
        case (op)
            5'd4:        r = a - b;
            5'd5:        r = a >> s;
            5'd6:        r = sa >>> s;
            5'd7:        r = a << s;
            5'd8:        r = (a >> s) | ((s == 0) ? 32'd0 : (a << (32 - s)));
            5'd9:        r = (a << s) | ((s == 0) ? 32'd0 : (a >> (32 - s)));
            5'd10, 5'd13: r = a & b;
            5'd11, 5'd14: r = a | b;
            5'd15: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            5'd16: begin
                if (sb == 0) return 64'd0;
                return {32'(sa % sb), 32'(sa / sb)};
            end
            5'd17:       r = 32'd0 - b;
            5'd18:       r = ~b;
            default:     r = a + b;
        endcase
        return {{32{r[31]}}, r};
    endfunction

    function automatic void model_update();
        logic [31:0] b;
        logic [63:0] r;
        logic [15:0] ld;
        if (!Clear) return;
        b  = model_bus();
        r  = model_alu(m_y, b, m_ir[31:27], IncPC);
        ld = REGin | (field_sel() & {16{Rin}});
        for (int i = 0; i < 16; i++)
            if (ld[i]) m_r[i] = b;
        if (CONin) begin
            case (m_ir[20:19])
                2'b00:   m_con = (b == 0);
                2'b01:   m_con = (b != 0);
                2'b10:   m_con = !b[31];
                default: m_con = b[31];
            endcase
        end
        if (PCin)      m_pc = b;
        if (IRin)      m_ir = b;
        if (MDRin)     m_mdr = Read ? Mdatain : b;
        if (Yin)       m_y = b;
        if (ZLowIn)    m_z[31:0] = r[31:0];
        if (ZHighIn)   m_z[63:32] = r[63:32];
        if (HIin)      m_hi = b;
        if (LOin)      m_lo = b;
        if (InPortIn)  m_in = InPort_data;
        if (OutPortIn) m_out = b;
    endfunction

    always @(negedge Clock) begin
        if (chk_en && Clear) begin
            check("bus", bus, model_bus());
            check("opcode", opcode, m_ir[31:27]);
            check("outport", OutPort_data, m_out);
        end
    end

    task automatic clr();
        {PCout, ZHighout, ZLowout, MDRout, HIout, LOout, Cout, InPortOut, BAout, Rout} = '0;
        {PCin, IRin, MARin, MDRin, Yin, ZHighIn, ZLowIn, HIin, LOin, CONin, InPortIn, OutPortIn, Rin} = '0;
        {IncPC, Read, RAMin, GRA, GRB, GRC} = '0;
        REGin = '0;
        REGout = '0;
    endtask

    task automatic go_nc();
        @(posedge Clock);
        model_update();
        #1;
        clr();
    endtask

    task automatic go(input string name, input logic [31:0] exp_bus);
        @(negedge Clock);
        check(name, bus, exp_bus);
        go_nc();
    endtask

    task automatic xfer(input logic [31:0] v, input logic [15:0] regs, input logic ir);
        InPort_data = v;
        InPortIn = 1'b1;
        go_nc();
        InPortOut = 1'b1;
        REGin = regs;
        IRin = ir;
        go_nc();
    endtask

    task automatic rand_inputs();
        PCout = ($urandom_range(0, 5) == 0);  ZHighout = ($urandom_range(0, 5) == 0);
        ZLowout = ($urandom_range(0, 5) == 0); MDRout = ($urandom_range(0, 5) == 0);
        HIout = ($urandom_range(0, 5) == 0);  LOout = ($urandom_range(0, 5) == 0);
        Cout = ($urandom_range(0, 5) == 0);   InPortOut = ($urandom_range(0, 5) == 0);
        BAout = ($urandom_range(0, 7) == 0);  Rout = ($urandom_range(0, 4) == 0);
        PCin = ($urandom_range(0, 3) == 0);   IRin = ($urandom_range(0, 3) == 0);
        MARin = ($urandom_range(0, 3) == 0);  MDRin = ($urandom_range(0, 3) == 0);
        Yin = ($urandom_range(0, 3) == 0);    ZHighIn = ($urandom_range(0, 3) == 0);
        ZLowIn = ($urandom_range(0, 3) == 0); HIin = ($urandom_range(0, 3) == 0);
        LOin = ($urandom_range(0, 3) == 0);   CONin = ($urandom_range(0, 3) == 0);
        InPortIn = ($urandom_range(0, 3) == 0); OutPortIn = ($urandom_range(0, 3) == 0);
        Rin = ($urandom_range(0, 3) == 0);    IncPC = ($urandom_range(0, 3) == 0);
        Read = ($urandom_range(0, 1) == 0);   RAMin = ($urandom_range(0, 1) == 0);
        GRA = ($urandom_range(0, 2) == 0);    GRB = ($urandom_range(0, 2) == 0);
        GRC = ($urandom_range(0, 2) == 0);
        REGin  = ($urandom_range(0, 3) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'd0;
        REGout = ($urandom_range(0, 5) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'd0;
        Mdatain = $urandom;
        InPort_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    endtask

    initial begin
        Clear = 1'b0;
        Mdatain = '0;
        InPort_data = '0;
        clr();
        model_reset();
        repeat (2) @(posedge Clock);
        #1 Clear = 1'b1;
        chk_en = 1'b1;

        @(negedge Clock);
        check("rst_bus", bus, 32'd0);
        check("rst_opcode", opcode, 5'd0);
        check("rst_outport", OutPort_data, 32'd0);
        go_nc();

        xfer(32'd10, 16'h0002, 1'b0);

        PCout = 1; MARin = 1; IncPC = 1; ZLowIn = 1;
        go("fetch_t0", 32'd0);
        ZLowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h610FFFFD;
        go("fetch_t1", 32'd1);
        MDRout = 1; IRin = 1;
        go("fetch_t2", 32'h610FFFFD);
        check("fetch_opcode", opcode, 5'b01100);
        GRB = 1; Rout = 1; Yin = 1;
        go("addi_t3", 32'd10);
        Cout = 1; ZLowIn = 1;
        go("addi_t4", 32'hFFFFFFFD);
        ZLowout = 1; GRA = 1; Rin = 1;
        go("addi_t5", 32'd7);
        GRA = 1; Rout = 1;
        go("addi_r2", 32'd7);

        xfer(32'hFFFFFFFE, 16'h0008, 1'b0);
        xfer(32'd3, 16'h0010, 1'b0);
        xfer(32'h78000000, 16'h0000, 1'b1);
        REGout = 16'h0008; Yin = 1;
        go("mul_a", 32'hFFFFFFFE);
        REGout = 16'h0010; ZLowIn = 1; ZHighIn = 1;
        go("mul_b", 32'd3);
        ZHighout = 1; HIin = 1; go_nc();
        ZLowout = 1; LOin = 1; go_nc();
        HIout = 1; go("mul_hi", 32'hFFFFFFFF);
        LOout = 1; go("mul_lo", 32'hFFFFFFFA);

        xfer(32'd17, 16'h0020, 1'b0);
        xfer(32'd5, 16'h0040, 1'b0);
        xfer(32'h80000000, 16'h0000, 1'b1);
        REGout = 16'h0020; Yin = 1; go_nc();
        REGout = 16'h0040; ZLowIn = 1; ZHighIn = 1; go_nc();
        ZHighout = 1; HIin = 1; go_nc();
        ZLowout = 1; LOin = 1; go_nc();
        LOout = 1; go("div_lo", 32'd3);
        HIout = 1; go("div_hi", 32'd2);
        ZLowIn = 1; ZHighIn = 1;
        go("div0_bus", 32'd0);
        ZLowout = 1; go("div0_zlo", 32'd0);
        ZHighout = 1; go("div0_zhi", 32'd0);

        xfer(32'h55, 16'h0001, 1'b0);
        GRA = 1; BAout = 1; go("baout_r0", 32'd0);
        GRA = 1; Rout = 1;  go("rout_r0", 32'h55);
        HIout = 1; LOout = 1; go("prio_hi_lo", 32'd2);
        PCout = 1; MDRout = 1; go("prio_pc_mdr", 32'd1);
        REGout = 16'h0001; HIout = 1; go("prio_reg_hi", 32'h55);

        InPort_data = 32'hABCD; InPortIn = 1; go_nc();
        InPortOut = 1; OutPortIn = 1; go("inport", 32'hABCD);
        check("outport_load", OutPort_data, 32'hABCD);

        HIout = 1;
        #2 Clear = 1'b0;
        model_reset();
        #1;
        check("midrst_bus", bus, 32'd0);
        check("midrst_opcode", opcode, 5'd0);
        check("midrst_outport", OutPort_data, 32'd0);
        @(posedge Clock);
        #1 Clear = 1'b1;
        clr();
        HIout = 1; go("hi_after_rst", 32'd0);

        repeat (3000) begin
            rand_inputs();
            go_nc();
        end

        @(negedge Clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- 32-bit bus-based CPU datapath driven cycle by cycle by an external control unit (or bench) through one-hot control strobes.
- Contains a 16x32 register file, PC, IR, MAR, MDR, Y, 64-bit Z, HI, LO, CON flip-flop, input port, output port and ALU, all sharing one 32-bit bus.
- The memory interface is external. MDR receives read data on Mdatain.

Parameters:
- DATA_W, 32, bus and register width (fixed; no other value supported).
- NUM_REGS, 16, general registers R0..R15.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Clear  in  1  asynchronous, active-low reset.
- PCout, ZHighout, ZLowout, MDRout, HIout, LOout, Cout, InPortOut, BAout, Rout  in  1 each  bus-source strobes.
- PCin, IRin, MARin, MDRin, Yin, ZHighIn, ZLowIn, HIin, LOin, CONin, InPortIn, OutPortIn, Rin  in  1 each  register load enables.
- IncPC  in  1  ALU computes bus+1 instead of the opcode operation.
- Read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
- RAMin  in  1  reserved memory-write strobe; no effect inside this block.
- GRA, GRB, GRC  in  1 each  select the IR Ra/Rb/Rc field for Rin/Rout/BAout.
- REGin, REGout  in  16  direct one-hot register load/drive (bit i = Ri).
- Mdatain  in  32  memory read data.
- InPort_data  in  32  external input-port data.
- opcode  out  5  IR[31:27].
- OutPort_data  out  32  output-port register.
- bus  out  32  current bus value.

Behaviour:
- Reset (Clear=0, asynchronous): every register (R0..R15, PC, IR, MAR, MDR, Y, Z, HI, LO, CON, InPort, OutPort) goes to 0. Resulting outputs: opcode=0, OutPort_data=0, bus=0.
- Register selection:
  - Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
  - The 4-to-16 decode of the field chosen by GRA/GRB/GRC gives sel[15:0].
  - Effective load vector = REGin | (sel & {16{Rin}}).
  - Effective drive vector = REGout | (sel & {16{Rout|BAout}}).
  - When BAout is asserted and R0 is driven, R0 reads as 0. Rout reads R0's true value.
- Bus mux (combinational):
  - Priority when several sources are asserted: R15..R0, HI, LO, ZHigh, ZLow, PC, MDR, InPort, C.
  - No source asserted -> bus = 0.
  - C = sign-extend(IR[18:0]).
- Register loads occur on the rising edge when enabled:
  - PC, IR, MAR, Y, HI, LO, OutPort load from bus.
  - MDR loads from Mdatain if Read, else from bus.
  - InPort loads InPort_data when InPortIn.
  - ZLowIn loads Z[31:0] and ZHighIn loads Z[63:32] from the ALU result.
- ALU (combinational, A=Y, B=bus, 64-bit result R):
  - IncPC=1 overrides the opcode: R={32'b0,B+1}.
  - Otherwise by opcode:
    - 00011 add / 01100 addi / 00000 ld / 00001 ldi / 00010 st: A+B.
    - 00100 sub: A-B.
    - 00101 shr, 00110 shra, 00111 shl: shift A by B[4:0].
    - 01000 ror, 01001 rol: rotate A by B[4:0].
    - 01010 and / 01101 andi: A&B.
    - 01011 or / 01110 ori: A|B.
    - 01111 mul: signed A*B, full 64-bit R.
    - 10000 div: R[31:0]=signed A/B, R[63:32]=remainder. Divisor 0 gives R=0.
    - 10001 neg: -B.
    - 10010 not: ~B.
    - Any other opcode: A+B.
  - For all non-mul/div operations, R[63:32] = sign of R[31:0] replicated; overflow wraps mod 2^32.
- CON: on CONin, loads a condition on the bus value using C2=IR[20:19]: 00 ==0, 01 !=0, 10 bit31==0, 11 bit31==1. CON is internal.
- Single-cycle latency for every register transfer. No handshakes.

Decomposition:
- Shared package holds:
  - opcode constants (5-bit);
  - IR field bit positions;
  - bus-source priority encoding.
- One natural sub-module: cpu_alu (combinational, 64-bit result). The register file stays inline.

Test Plan:
- Reset: Clear=0 mid-run -> bus=0, opcode=0, OutPort_data=0 immediately, without waiting for a clock edge.
- Fetch (PC=0):
  - T0: PCout, MARin, IncPC, ZLowIn -> MAR=0, Z low=1.
  - T1: ZLowout, PCin, Read, MDRin with Mdatain=0x610FFFFD -> PC=1.
  - T2: MDRout, IRin -> opcode=5'b01100.
- addi R2,R1,-3 (R1=10 preloaded via REGin):
  - T3: GRB, Rout, Yin -> Y=10.
  - T4: Cout, ZLowIn -> bus=0xFFFFFFFD.
  - T5: ZLowout, GRA, Rin -> R2=7.
- mul with R3=0xFFFFFFFE, R4=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- div 17/5 -> LO=3, HI=2.
- BAout with R0=0x55 -> bus=0; Rout on R0 -> bus=0x55.
- Ports:
  - InPort_data=0xABCD with InPortIn then InPortOut -> bus=0xABCD.
  - OutPortIn -> OutPort_data=0xABCD.
